// File: rtl/memo_write_arbiter.sv
// Round-robin write arbiter for one shared register written by NREQ requesters.
// Supports locked multi-cycle ownership. All outputs come straight from registers.
module memo_write_arbiter #(
  parameter  int NREQ  = 4,
  parameter  int WIDTH = 8,
  localparam int IDXW  = $clog2(NREQ)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ-1:0]       lock,
  input  logic [NREQ*WIDTH-1:0] wdata,
  output logic [NREQ-1:0]       gnt,
  output logic [IDXW-1:0]       owner,
  output logic [WIDTH-1:0]      q,
  output logic                  q_valid
);

  typedef enum logic {IDLE, HELD} state_t;

  state_t            state_reg, state_next;
  logic [IDXW-1:0]   ptr_reg, ptr_next;
  logic [NREQ-1:0]   gnt_reg, gnt_next;
  logic [IDXW-1:0]   owner_reg, owner_next;
  logic [WIDTH-1:0]  q_reg, q_next;
  logic              q_valid_reg, q_valid_next;

  logic [WIDTH-1:0]  wdata_arr [NREQ];
  logic              found;
  logic [IDXW-1:0]   win;
  logic [IDXW:0]     cand;

  for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
    assign wdata_arr[gi] = wdata[gi*WIDTH +: WIDTH];
  end

  // First set request scanning from ptr, wrapping modulo NREQ (cand never reaches NREQ).
  always_comb begin
    found = 1'b0;
    win   = ptr_reg;
    cand  = '0;
    for (int k = 0; k < NREQ; k++) begin
      cand = {1'b0, ptr_reg} + (IDXW+1)'(k);
      if (cand >= (IDXW+1)'(NREQ))
        cand = cand - (IDXW+1)'(NREQ);
      if (!found && req[cand[IDXW-1:0]]) begin
        found = 1'b1;
        win   = cand[IDXW-1:0];
      end
    end
  end

  always_comb begin
    state_next   = state_reg;
    ptr_next     = ptr_reg;
    gnt_next     = gnt_reg;
    owner_next   = owner_reg;
    q_next       = q_reg;
    q_valid_next = 1'b0;
    case (state_reg)
      IDLE: begin
        if (found) begin
          gnt_next     = NREQ'(1) << win;
          owner_next   = win;
          q_next       = wdata_arr[win];
          q_valid_next = 1'b1;
          ptr_next     = (win == IDXW'(NREQ-1)) ? '0 : win + IDXW'(1);
          if (lock[win])
            state_next = HELD;
        end else begin
          gnt_next = '0;
        end
      end
      HELD: begin
        if (req[owner_reg] && lock[owner_reg]) begin
          q_next       = wdata_arr[owner_reg];
          q_valid_next = 1'b1;
        end else begin
          // Release edge: no arbitration here, so the next grant is one cycle later.
          state_next = IDLE;
          gnt_next   = '0;
        end
      end
      default: begin
        state_next = IDLE;
        gnt_next   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= IDLE;
      ptr_reg     <= '0;
      gnt_reg     <= '0;
      owner_reg   <= '0;
      q_reg       <= '0;
      q_valid_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      ptr_reg     <= ptr_next;
      gnt_reg     <= gnt_next;
      owner_reg   <= owner_next;
      q_reg       <= q_next;
      q_valid_reg <= q_valid_next;
    end
  end

  assign gnt     = gnt_reg;
  assign owner   = owner_reg;
  assign q       = q_reg;
  assign q_valid = q_valid_reg;

endmodule

// File: tb/tb_memo_write_arbiter.sv
// Directed bench for memo_write_arbiter: a 4-requester instance and a 3-requester
// instance for pointer wrap, checked with immediate assertions against hand-computed values.
module tb_memo_write_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [3:0]  req_a = '0, lock_a = '0;
  logic [31:0] wdata_a = '0;
  logic [3:0]  gnt_a;
  logic [1:0]  owner_a;
  logic [7:0]  q_a;
  logic        qv_a;
  logic [2:0]  req_b = '0, lock_b = '0;
  logic [23:0] wdata_b = '0;
  logic [2:0]  gnt_b;
  logic [1:0]  owner_b;
  logic [7:0]  q_b;
  logic        qv_b;

  int n_checks = 0;
  int n_fail   = 0;

  memo_write_arbiter #(.NREQ(4), .WIDTH(8)) dut_a (
    .clk(clk), .rst_n(rst_n), .req(req_a), .lock(lock_a), .wdata(wdata_a),
    .gnt(gnt_a), .owner(owner_a), .q(q_a), .q_valid(qv_a)
  );

  memo_write_arbiter #(.NREQ(3), .WIDTH(8)) dut_b (
    .clk(clk), .rst_n(rst_n), .req(req_b), .lock(lock_b), .wdata(wdata_b),
    .gnt(gnt_b), .owner(owner_b), .q(q_b), .q_valid(qv_b)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_a(input string tag, input logic [3:0] g, input logic [1:0] o,
                          input logic [7:0] d, input logic v);
    check({tag, "_gnt"}, 32'(gnt_a), 32'(g));
    check({tag, "_owner"}, 32'(owner_a), 32'(o));
    check({tag, "_q"}, 32'(q_a), 32'(d));
    check({tag, "_qv"}, 32'(qv_a), 32'(v));
    $display("step %s: gnt=%b owner=%0d q=%h q_valid=%b", tag, gnt_a, owner_a, q_a, qv_a);
  endtask

  task automatic expect_b(input string tag, input logic [2:0] g, input logic [1:0] o,
                          input logic [7:0] d, input logic v);
    check({tag, "_gnt"}, 32'(gnt_b), 32'(g));
    check({tag, "_owner"}, 32'(owner_b), 32'(o));
    check({tag, "_q"}, 32'(q_b), 32'(d));
    check({tag, "_qv"}, 32'(qv_b), 32'(v));
    $display("step %s: gnt=%b owner=%0d q=%h q_valid=%b", tag, gnt_b, owner_b, q_b, qv_b);
  endtask

  initial begin
    // Power-on reset
    #1 rst_n = 1'b0;
    #1;
    expect_a("reset", 4'b0000, 2'd0, 8'h00, 1'b0);
    expect_b("reset_b", 3'b000, 2'd0, 8'h00, 1'b0);
    @(posedge clk);
    #2 rst_n = 1'b1;

    // Test 1: single requester 2
    req_a = 4'b0100; wdata_a[16 +: 8] = 8'hA5;
    step();
    expect_a("t1", 4'b0100, 2'd2, 8'hA5, 1'b1);
    // ptr is now 3: requester 3 beats requester 0
    req_a = 4'b1001; wdata_a[0 +: 8] = 8'hC0; wdata_a[24 +: 8] = 8'h3C;
    step();
    expect_a("t1_ptr", 4'b1000, 2'd3, 8'h3C, 1'b1);

    // Asynchronous reset between cycles clears outputs immediately
    req_a = 4'b0000;
    rst_n = 1'b0;
    #1;
    expect_a("rst_async", 4'b0000, 2'd0, 8'h00, 1'b0);
    #2 rst_n = 1'b1;

    // Test 2: full contention from ptr=0
    wdata_a = 32'h44332211;
    req_a = 4'b1111;
    step(); expect_a("t2_c0", 4'b0001, 2'd0, 8'h11, 1'b1);
    step(); expect_a("t2_c1", 4'b0010, 2'd1, 8'h22, 1'b1);
    step(); expect_a("t2_c2", 4'b0100, 2'd2, 8'h33, 1'b1);
    step(); expect_a("t2_c3", 4'b1000, 2'd3, 8'h44, 1'b1);
    step(); expect_a("t2_c4", 4'b0001, 2'd0, 8'h11, 1'b1);
    step(); expect_a("t2_c5", 4'b0010, 2'd1, 8'h22, 1'b1);

    // ptr=2: requester 0 alone wins, ptr becomes 1
    req_a = 4'b0001; wdata_a[0 +: 8] = 8'h0F;
    step(); expect_a("t3_pre", 4'b0001, 2'd0, 8'h0F, 1'b1);

    // Test 3: locked ownership by requester 1 while requester 3 waits
    req_a = 4'b1010; lock_a = 4'b0010;
    wdata_a[8 +: 8] = 8'h11; wdata_a[24 +: 8] = 8'h99;
    step(); expect_a("t3_l0", 4'b0010, 2'd1, 8'h11, 1'b1);
    wdata_a[8 +: 8] = 8'h22;
    step(); expect_a("t3_l1", 4'b0010, 2'd1, 8'h22, 1'b1);
    wdata_a[8 +: 8] = 8'h33;
    step(); expect_a("t3_l2", 4'b0010, 2'd1, 8'h33, 1'b1);
    lock_a = 4'b0000; wdata_a[8 +: 8] = 8'h44;
    step(); expect_a("t3_rel", 4'b0000, 2'd1, 8'h33, 1'b0);
    step(); expect_a("t3_next", 4'b1000, 2'd3, 8'h99, 1'b1);

    // Release by dropping req while lock stays high (ptr=0 here)
    req_a = 4'b0001; lock_a = 4'b0001; wdata_a[0 +: 8] = 8'h77;
    step(); expect_a("rq_grant", 4'b0001, 2'd0, 8'h77, 1'b1);
    req_a = 4'b0000; wdata_a[0 +: 8] = 8'h78;
    step(); expect_a("rq_rel", 4'b0000, 2'd0, 8'h77, 1'b0);
    lock_a = 4'b0000;

    // Test 6: idle hold for 4 cycles
    for (int i = 0; i < 4; i++) begin
      step();
      expect_a($sformatf("t6_idle%0d", i), 4'b0000, 2'd0, 8'h77, 1'b0);
    end

    // Test 5: reset mid-lock at owner 2 (ptr=1 here)
    req_a = 4'b0100; lock_a = 4'b0100; wdata_a[16 +: 8] = 8'h55;
    step(); expect_a("t5_grant", 4'b0100, 2'd2, 8'h55, 1'b1);
    wdata_a[16 +: 8] = 8'h66;
    step(); expect_a("t5_held", 4'b0100, 2'd2, 8'h66, 1'b1);
    rst_n = 1'b0;
    #1;
    expect_a("t5_rst", 4'b0000, 2'd0, 8'h00, 1'b0);
    req_a = 4'b0110; lock_a = 4'b0000; wdata_a[8 +: 8] = 8'hE1;
    #2 rst_n = 1'b1;
    step(); expect_a("t5_after", 4'b0010, 2'd1, 8'hE1, 1'b1);
    req_a = 4'b0000;

    // Test 4: NREQ=3 pointer wrap
    wdata_b = 24'hB2B1B0;
    req_b = 3'b100;
    step(); expect_b("t4_w2", 3'b100, 2'd2, 8'hB2, 1'b1);
    req_b = 3'b011;
    step(); expect_b("t4_w0", 3'b001, 2'd0, 8'hB0, 1'b1);
    step(); expect_b("t4_w1", 3'b010, 2'd1, 8'hB1, 1'b1);
    req_b = 3'b000;
    step(); expect_b("t4_idle", 3'b000, 2'd1, 8'hB1, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/memo_write_arbiter.md
# memo_write_arbiter

Round-robin write arbiter that shares one registered storage element between NREQ requesters. Each requester would otherwise drive the register directly, producing the continuous/procedural multi-driver conflict that elaboration must reject. The arbiter gives exactly one requester write ownership per cycle and supports locked multi-cycle ownership. It sits between requester logic and the shared register, and its output q is that register.

## Interface

Parameters:
- NREQ, 4, number of requesters; legal range 2..16.
- WIDTH, 8, data width of the shared register.
- IDXW, $clog2(NREQ), width of the owner index (derived; not overridden).

Ports:
- clk, input, 1, rising-edge clock.
- rst_n, input, 1, asynchronous active-low reset.
- req, input, NREQ, per-requester write request; bit i belongs to requester i.
- lock, input, NREQ, per-requester lock; lock[i] is sampled only while i owns or is being granted.
- wdata, input, NREQ*WIDTH, packed write data; requester i uses wdata[i*WIDTH +: WIDTH].
- gnt, output, NREQ, registered one-hot grant, or all-zero.
- owner, output, IDXW, registered index of the current grantee; holds its last value when gnt is zero.
- q, output, WIDTH, shared register contents.
- q_valid, output, 1, high for each cycle in which q was written on the preceding edge.

## Operation

- State: IDLE, HELD. Round-robin pointer ptr is IDXW bits wide.
- Reset (async, immediate): state=IDLE, ptr=0, gnt=0, owner=0, q=0, q_valid=0.
- IDLE, req==0: gnt<=0, q_valid<=0, q holds, ptr holds.
- IDLE, req!=0 (arbitration):
  - Winner w is the first set req bit scanning ptr, ptr+1, … modulo NREQ.
  - Updates: gnt<=1<<w, owner<=w, q<=wdata[w], q_valid<=1, ptr<=(w+1) mod NREQ.
  - If lock[w]=1, state<=HELD; otherwise state stays IDLE.
- HELD with owner o, req[o]=1 and lock[o]=1:
  - gnt holds, q<=wdata[o], q_valid<=1.
  - Other requesters are ignored. ptr holds.
- HELD, req[o]=0 or lock[o]=0 (release):
  - state<=IDLE, gnt<=0, q_valid<=0, q holds.
  - No arbitration happens on the release edge, so there is one dead cycle before the next grant.
  - A release cycle with req[o]=1, lock[o]=0 does not write q.
- Back-to-back unlocked grants are legal with no bubble. IDLE arbitrates every edge while req!=0.
- ptr wraps from NREQ-1 to 0. When NREQ is not a power of two, ptr never takes values ≥NREQ.
- gnt is never multi-hot. Whenever gnt is nonzero, gnt==1<<owner.
- Requester data is sampled only on its grant edge. wdata of non-winners is don't-care.

## Timing

- req to gnt/q/q_valid latency: 1 clock (all outputs registered; no combinational input-to-output path).
- Requester i must hold req[i] until it observes gnt[i]=1. The arbiter does not remember dropped requests.
- Locked ownership for K cycles costs K write cycles plus 1 release cycle.
- Asynchronous reset deassertion is synchronized externally. The first arbitration can occur on the first rising edge after rst_n rises.
- Reset asserted during HELD clears all state immediately. After reset, ptr=0, so requester 0 has priority.

## Test plan

1. Single requester: reset, req=4'b0100, wdata[2]=8'hA5, lock=0.
   - One edge later: gnt=4'b0100, owner=2, q=8'hA5, q_valid=1, ptr=3.
2. Full contention: req=4'b1111 held for 6 cycles, no lock.
   - Grant order is 0,1,2,3,0,1; q tracks each winner's wdata; q_valid stays 1 throughout.
3. Locked ownership: requester 1 with lock[1]=1 for 3 cycles while req[3]=1 and wdata[1] changes 11,22,33.
   - gnt=4'b0010 for 3 cycles and q=11,22,33.
   - Lock drop gives gnt=0, q_valid=0 for 1 cycle.
   - The next edge gives gnt=4'b1000.
4. Pointer wrap with NREQ=3:
   - req=3'b100 gives grant 2, and ptr returns to 0.
   - Then req=3'b011 gives grant 0, then 1.
5. Reset mid-lock: assert rst_n=0 asynchronously while HELD at owner 2.
   - Outputs clear immediately: gnt=0, q=0, q_valid=0.
   - After release with req=4'b0110, the first grant goes to 1.
6. Idle hold: the grant stream ends, then req=0 for 4 cycles.
   - q retains the last value, gnt=0, q_valid=0, owner retains the last index.
